// File: rtl/fp16_pkg.sv
// Shared constants for the binary16 arithmetic units: field widths, bias,
// canonical special encodings and the divider FSM state codes.
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int QI    = MAN_W + 4;  // 1 integer bit, MAN_W fraction bits, guard, round, extra

  localparam logic [15:0] QNAN = 16'h7FFF;
  localparam logic [15:0] PINF = 16'h7C00;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_NORM = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/fp_divider_special_case.sv
// Combinational classification of an fp16 divide: flags operand combinations whose
// result does not need the mantissa datapath and supplies that result directly.
module fp_divider_special_case
  import fp16_pkg::*;
(
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         is_special,
  output logic [W-1:0] special_result
);

  logic [EXP_W-1:0] ex, ey;
  logic [MAN_W-1:0] mx, my;
  logic             x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, sign;

  assign ex = x[W-2:MAN_W];
  assign ey = y[W-2:MAN_W];
  assign mx = x[MAN_W-1:0];
  assign my = y[MAN_W-1:0];

  assign x_nan  = (&ex) & (|mx);
  assign y_nan  = (&ey) & (|my);
  assign x_inf  = (&ex) & ~(|mx);
  assign y_inf  = (&ey) & ~(|my);
  // Subnormals are flushed, so an all-zero exponent means zero regardless of mantissa.
  assign x_zero = ~(|ex);
  assign y_zero = ~(|ey);
  assign sign   = x[W-1] ^ y[W-1];

  always_comb begin
    is_special     = 1'b1;
    special_result = QNAN;
    if (x_nan | y_nan) begin
      special_result = QNAN;
    end else if ((x_inf & y_inf) | (x_zero & y_zero)) begin
      special_result = QNAN;
    end else if (x_inf | y_zero) begin
      special_result = {sign, PINF[W-2:0]};
    end else if (y_inf | x_zero) begin
      special_result = {sign, {(W-1){1'b0}}};
    end else begin
      is_special     = 1'b0;
      special_result = {W{1'b0}};
    end
  end

endmodule

// File: rtl/fp_divider.sv
// Iterative fp16 divider: restoring radix-2 mantissa division, one quotient bit
// per cycle, then a single normalise/round-to-nearest-even cycle.
module fp_divider
  import fp16_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] r,
  output logic         negative,
  output logic         zero,
  output logic         overflow,
  output logic         cout
);

  localparam int RW = MAN_W + 2;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(QI);
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_ZERO = '0;

  logic [1:0]       state_reg;
  logic             sign_reg;
  logic [EXP_W-1:0] ex_reg, ey_reg;
  logic [MAN_W:0]   div_reg;
  logic [RW-1:0]    rem_reg;
  logic [QI-1:0]    q_reg;
  logic [CW-1:0]    cnt_reg;
  logic             special_reg;
  logic [W-1:0]     special_result_reg;
  logic [W-1:0]     r_reg;

  logic             is_special;
  logic [W-1:0]     special_result;

  fp_divider_special_case u_special (
    .x              (x),
    .y              (y),
    .is_special     (is_special),
    .special_result (special_result)
  );

  // Compare-then-shift: the first quotient bit is the integer bit of mx/my.
  logic [RW-1:0] div_ext, rem_sub, rem_next;
  logic          rem_ge;

  assign div_ext  = {1'b0, div_reg};
  assign rem_ge   = rem_reg >= div_ext;
  assign rem_sub  = rem_ge ? (rem_reg - div_ext) : rem_reg;
  assign rem_next = {rem_sub[RW-2:0], 1'b0};

  logic                   adj, guard, round_bit, sticky_bit, round_up, carry;
  logic [QI-1:0]          q_norm;
  logic [MAN_W-1:0]       mant;
  logic [MAN_W:0]         mant_sum;
  logic signed [EW-1:0]   e_val;
  logic [W-1:0]           norm_result;

  assign adj        = ~q_reg[QI-1];
  assign q_norm     = adj ? {q_reg[QI-2:0], 1'b0} : q_reg;
  assign mant       = q_norm[QI-2 -: MAN_W];
  assign guard      = q_norm[2];
  assign round_bit  = q_norm[1];
  assign sticky_bit = q_norm[0] | (|rem_reg);
  assign round_up   = guard & (round_bit | sticky_bit | mant[0]);
  assign mant_sum   = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
  assign carry      = mant_sum[MAN_W];
  assign e_val      = EW'(ex_reg) - EW'(ey_reg) + EW'(BIAS) - EW'(adj) + EW'(carry);

  always_comb begin
    norm_result = {sign_reg, e_val[EXP_W-1:0], mant_sum[MAN_W-1:0]};
    if (special_reg) begin
      norm_result = special_result_reg;
    end else if (e_val >= E_MAX) begin
      norm_result = {sign_reg, PINF[W-2:0]};
    end else if (e_val <= E_ZERO) begin
      norm_result = {sign_reg, {(W-1){1'b0}}};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg          <= ST_IDLE;
      sign_reg           <= 1'b0;
      ex_reg             <= '0;
      ey_reg             <= '0;
      div_reg            <= '0;
      rem_reg            <= '0;
      q_reg              <= '0;
      cnt_reg            <= '0;
      special_reg        <= 1'b0;
      special_result_reg <= '0;
      r_reg              <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            sign_reg           <= x[W-1] ^ y[W-1];
            ex_reg             <= x[W-2:MAN_W];
            ey_reg             <= y[W-2:MAN_W];
            div_reg            <= {1'b1, y[MAN_W-1:0]};
            rem_reg            <= {1'b0, 1'b1, x[MAN_W-1:0]};
            q_reg              <= '0;
            cnt_reg            <= '0;
            special_reg        <= is_special;
            special_result_reg <= special_result;
            state_reg          <= is_special ? ST_NORM : ST_DIV;
          end
        end
        ST_DIV: begin
          rem_reg <= rem_next;
          q_reg   <= {q_reg[QI-2:0], rem_ge};
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == CW'(QI - 1)) begin
            state_reg <= ST_NORM;
          end
        end
        ST_NORM: begin
          r_reg     <= norm_result;
          state_reg <= ST_DONE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = state_reg != ST_IDLE;
  assign done     = state_reg == ST_DONE;
  assign r        = r_reg;
  assign negative = r_reg[W-1];
  assign zero     = ~(|r_reg[W-2:0]);
  assign overflow = &r_reg[W-2:MAN_W];
  assign cout     = 1'b0;

endmodule

// File: tb/tb_fp_divider.sv
// Scoreboard bench for fp_divider: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every done pulse.
module tb_fp_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] x, y;
  logic        busy, done, negative, zero, overflow, cout;
  logic [15:0] r;

  fp_divider dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .x        (x),
    .y        (y),
    .busy     (busy),
    .done     (done),
    .r        (r),
    .negative (negative),
    .zero     (zero),
    .overflow (overflow),
    .cout     (cout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] r;
    int          lat;
    int          t0;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [3:0] mon_flags_exp;
  logic [3:0] mon_flags_got;

  // Directed vectors: x, y, expected r, expected latency
  logic [15:0] vx  [0:11] = '{16'h3C00, 16'h4500, 16'h7BFF, 16'h0400, 16'h4000, 16'hC400,
                              16'h4200, 16'h3C00, 16'h0000, 16'hC000, 16'h7E00, 16'h0001};
  logic [15:0] vy  [0:11] = '{16'h4200, 16'h4200, 16'h3800, 16'h4000, 16'h3C00, 16'h4000,
                              16'h3C00, 16'h0000, 16'h0000, 16'h7C00, 16'h3C00, 16'h3C00};
  logic [15:0] vr  [0:11] = '{16'h3555, 16'h3EAB, 16'h7C00, 16'h0000, 16'h4000, 16'hC000,
                              16'h4200, 16'h7C00, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h0000};
  int          vl  [0:11] = '{15, 15, 15, 15, 15, 15, 15, 1, 1, 1, 1, 1};

  // Monitor
  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done got r=%h want no done", r);
      end else begin
        mon_e = sb.pop_front();
        if (r !== mon_e.r) begin
          errors++;
          $display("FAIL result got r=%h want %h", r, mon_e.r);
        end
        mon_flags_exp = {mon_e.r[15], ~(|mon_e.r[14:0]), &mon_e.r[14:10], 1'b0};
        mon_flags_got = {negative, zero, overflow, cout};
        checks++;
        if (mon_flags_got !== mon_flags_exp) begin
          errors++;
          $display("FAIL flags got nzoc=%b want %b (r=%h)", mon_flags_got, mon_flags_exp, mon_e.r);
        end
        checks++;
        if ((cyc - mon_e.t0) != mon_e.lat) begin
          errors++;
          $display("FAIL latency got %0d want %0d (r=%h)", cyc - mon_e.t0, mon_e.lat, mon_e.r);
        end
        $display("done r=%h want=%h nzoc=%b latency=%0d", r, mon_e.r, mon_flags_got, cyc - mon_e.t0);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL timeout got busy=%b want 0 within 100 cycles", busy);
    end
  endtask

  task automatic issue(input logic [15:0] xi, input logic [15:0] yi,
                       input logic [15:0] er, input int lat);
    wait_idle();
    x     = xi;
    y     = yi;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    sb.push_back('{r: er, lat: lat, t0: cyc});
  endtask

  initial begin
    int busy_lo;
    reset = 1'b1;
    start = 1'b0;
    x     = 16'h0000;
    y     = 16'h0000;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, r, overflow, zero, negative} !== {1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got busy=%b done=%b r=%h o=%b z=%b n=%b want 0 0 0000 0 1 0",
               busy, done, r, overflow, zero, negative);
    end
    reset = 1'b0;

    // 1/2 with busy held high until and through the done cycle
    issue(16'h3C00, 16'h4000, 16'h3800, 15);
    busy_lo = 0;
    repeat (16) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_lo++;
    end
    checks++;
    if (busy_lo != 0) begin
      errors++;
      $display("FAIL busy_throughout got %0d low cycles want 0", busy_lo);
    end

    for (int i = 0; i < 12; i++) begin
      issue(vx[i], vy[i], vr[i], vl[i]);
    end

    // start re-pulsed mid-DIV must be ignored
    issue(16'h4500, 16'h4200, 16'h3EAB, 15);
    repeat (5) @(negedge clk);
    x     = 16'h3C00;
    y     = 16'h4000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (20) @(negedge clk);

    // back-to-back: the second start lands in the first IDLE cycle after done
    issue(16'h3C00, 16'h4200, 16'h3555, 15);
    issue(16'hC400, 16'h4000, 16'hC000, 15);

    // reset during DIV iteration 7
    issue(16'h3C00, 16'h4200, 16'h3555, 15);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, r} !== {1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL mid_reset got busy=%b done=%b r=%h want 0 0 0000", busy, done, r);
    end
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    issue(16'h4500, 16'h4200, 16'h3EAB, 15);

    wait_idle();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL pending got %0d outstanding results want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got simulation still running want finished");
    $fatal(1, "watchdog");
  end

endmodule
